multicycle_controller: RTL and testbench
========================================

MULTICYCLE_CONTROLLER -- requirements
Module: multicycle_controller

Interface
REQ-001 The block SHALL have parameter MEM_TIMEOUT, default 16, meaning max cycles spent waiting on mem_ready per memory access (range 2..255).
REQ-002 The block SHALL have port clk  input  1  single system clock, all state on rising edge.
REQ-003 The block SHALL have port reset  input  1  asynchronous, active-high reset.
REQ-004 The block SHALL have port op  input  7  opcode field of the instruction register.
REQ-005 The block SHALL have port zero  input  1  ALU zero flag, used for beq.
REQ-006 The block SHALL have port mem_ready  input  1  memory completes current access this cycle.
REQ-007 The block SHALL have ports mem_req/mem_write  output  1/1  access request / write enable toward memory.
REQ-008 The block SHALL have ports pc_write, ir_write, reg_write, adr_src  output  1 each  datapath strobes; adr_src 0=PC, 1=result.
REQ-009 The block SHALL have ports alu_src_a, alu_src_b, alu_op, result_src  output  2 each  mux/ALU selects.
REQ-010 The block SHALL have port imm_src  output  3  immediate-extender select: I=000, S=001, B=010, J=011, U=100, R/other=111.
REQ-011 The block SHALL have port err  output  1  sticky fault flag (illegal opcode or memory timeout).

Function
REQ-012 The block SHALL be a Moore FSM with states FETCH, DECODE, MEMADR, MEMREAD, MEMWB, MEMWRITE, EXECR, EXECI, ALUWB, BEQ, JAL, LUI, FAULT; all outputs except strobes gated by mem_ready SHALL depend on state only.
REQ-013 Select encodings SHALL be: alu_src_a 00=PC, 01=oldPC, 10=rd1, 11=zero; alu_src_b 00=rd2, 01=imm_ext, 10=const 4; alu_op 00=add, 01=sub, 10=funct decode; result_src 00=alu_out, 01=data, 10=alu_result.
REQ-014 FETCH SHALL drive mem_req=1, adr_src=0, alu_src_a=00, alu_src_b=10, alu_op=00, result_src=10, and assert ir_write and pc_write only in the cycle mem_ready=1, then go to DECODE.
REQ-015 DECODE SHALL drive alu_src_a=01, alu_src_b=01, alu_op=00 and branch on op: 0000011/0100011 -> MEMADR, 0110011 -> EXECR, 0010011 -> EXECI, 1100011 -> BEQ, 1101111 -> JAL, 0110111 -> LUI, any other -> FAULT.
REQ-016 imm_src SHALL be a combinational decode of op per REQ-010 in every state.
REQ-017 MEMADR (alu_src_a=10, alu_src_b=01, alu_op=00) SHALL go to MEMREAD for loads, MEMWRITE for stores.
REQ-018 MEMREAD (mem_req=1, adr_src=1, result_src=00) SHALL hold until mem_ready=1, then go to MEMWB; MEMWB (result_src=01, reg_write=1) SHALL go to FETCH.
REQ-019 MEMWRITE (mem_req=1, mem_write=1, adr_src=1, result_src=00) SHALL hold until mem_ready=1, then go to FETCH.
REQ-020 EXECR (10/00/10) and EXECI (10/01/10) SHALL go to ALUWB; ALUWB (result_src=00, reg_write=1) SHALL go to FETCH.
REQ-021 BEQ (alu_src_a=10, alu_src_b=00, alu_op=01, result_src=00) SHALL assert pc_write iff zero=1, then go to FETCH.
REQ-022 JAL (alu_src_a=01, alu_src_b=10, alu_op=00, result_src=00, pc_write=1) SHALL go to ALUWB.
REQ-023 LUI (alu_src_a=11, alu_src_b=01, alu_op=00) SHALL go to ALUWB.
REQ-024 A wait counter SHALL clear on entry to FETCH/MEMREAD/MEMWRITE, increment each cycle mem_ready=0, and on reaching MEM_TIMEOUT SHALL force FAULT; mem_ready=1 in the same cycle the count reaches MEM_TIMEOUT SHALL win (access completes).
REQ-025 FAULT SHALL drive err=1 and all strobes/mem_req to 0 and SHALL be left only by reset.
REQ-026 Strobes not listed for a state SHALL be 0; unlisted selects SHALL be 00.

Reset
REQ-027 Reset SHALL asynchronously force state=FETCH, wait counter=0, err=0; mem_req=1 and all other strobes 0 while reset is high; an access in flight SHALL be abandoned.
REQ-028 The first fetch SHALL begin on the first rising clk after reset deasserts.

Configuration
REQ-029 Macro CTRL_MEM_TIMEOUT_EN SHALL gate the timeout: defined -> REQ-024 applies; undefined -> no counter is built, waits are unbounded, err asserts only for illegal opcode.

Verification
REQ-030 lw with mem_ready=1 every cycle -> FETCH,DECODE,MEMADR,MEMREAD,MEMWB; 5 cycles, reg_write=1 in cycle 5, result_src=01.
REQ-031 sw with mem_ready delayed 3 cycles in MEMWRITE -> mem_write=1 held 4 cycles, no reg_write, return to FETCH.
REQ-032 beq with zero=1 then zero=0 -> pc_write=1 in BEQ only for first; 3 cycles each.
REQ-033 op=7'b1111111 -> err=1 one cycle after DECODE, stays 1 with mem_req=0 until reset.
REQ-034 With macro, MEM_TIMEOUT=4, mem_ready held 0 in FETCH -> FAULT after 4 cycles; mem_ready=1 on 4th cycle -> DECODE instead.
REQ-035 Reset asserted mid-MEMREAD -> state FETCH immediately (same cycle, no clock), err=0, no reg_write.

Source files
------------

// File: rtl/multicycle_controller.sv
// Multicycle RV32 subset control FSM (lw, sw, R, I, beq, jal, lui) with a sticky fault flag.
// Define CTRL_MEM_TIMEOUT_EN to bound every memory wait to MEM_TIMEOUT cycles.
module multicycle_controller #(
    parameter int unsigned MEM_TIMEOUT = 16
) (
    input  logic       clk,
    input  logic       reset,
    input  logic [6:0] op,
    input  logic       zero,
    input  logic       mem_ready,
    output logic       mem_req,
    output logic       mem_write,
    output logic       pc_write,
    output logic       ir_write,
    output logic       reg_write,
    output logic       adr_src,
    output logic [1:0] alu_src_a,
    output logic [1:0] alu_src_b,
    output logic [1:0] alu_op,
    output logic [1:0] result_src,
    output logic [2:0] imm_src,
    output logic       err
);

    typedef enum logic [3:0] {
        S_FETCH    = 4'd0,
        S_DECODE   = 4'd1,
        S_MEMADR   = 4'd2,
        S_MEMREAD  = 4'd3,
        S_MEMWB    = 4'd4,
        S_MEMWRITE = 4'd5,
        S_EXECR    = 4'd6,
        S_EXECI    = 4'd7,
        S_ALUWB    = 4'd8,
        S_BEQ      = 4'd9,
        S_JAL      = 4'd10,
        S_LUI      = 4'd11,
        S_FAULT    = 4'd12
    } state_t;

    localparam logic [6:0] OP_LOAD   = 7'b0000011;
    localparam logic [6:0] OP_STORE  = 7'b0100011;
    localparam logic [6:0] OP_R      = 7'b0110011;
    localparam logic [6:0] OP_I      = 7'b0010011;
    localparam logic [6:0] OP_BRANCH = 7'b1100011;
    localparam logic [6:0] OP_JAL    = 7'b1101111;
    localparam logic [6:0] OP_LUI    = 7'b0110111;

    typedef struct packed {
        logic       mem_req;
        logic       mem_write;
        logic       pc_write;
        logic       reg_write;
        logic       adr_src;
        logic       err;
        logic       fetch_gate;
        logic       beq_gate;
        logic [1:0] alu_src_a;
        logic [1:0] alu_src_b;
        logic [1:0] alu_op;
        logic [1:0] result_src;
    } outs_t;

    if (MEM_TIMEOUT < 2 || MEM_TIMEOUT > 255) begin : g_bad_timeout
        $error("MEM_TIMEOUT must lie in 2..255");
    end

    state_t state_q, state_d;
    outs_t  outs_q;
    logic   timeout_s;

    // Moore output table; the fetch/beq gates are qualified by live inputs later.
    function automatic outs_t decode_outs(input state_t s);
        outs_t o;
        o = '0;
        case (s)
            S_FETCH:    begin o.mem_req = 1'b1; o.alu_src_b = 2'b10; o.result_src = 2'b10; o.fetch_gate = 1'b1; end
            S_DECODE:   begin o.alu_src_a = 2'b01; o.alu_src_b = 2'b01; end
            S_MEMADR:   begin o.alu_src_a = 2'b10; o.alu_src_b = 2'b01; end
            S_MEMREAD:  begin o.mem_req = 1'b1; o.adr_src = 1'b1; end
            S_MEMWB:    begin o.reg_write = 1'b1; o.result_src = 2'b01; end
            S_MEMWRITE: begin o.mem_req = 1'b1; o.mem_write = 1'b1; o.adr_src = 1'b1; end
            S_EXECR:    begin o.alu_src_a = 2'b10; o.alu_op = 2'b10; end
            S_EXECI:    begin o.alu_src_a = 2'b10; o.alu_src_b = 2'b01; o.alu_op = 2'b10; end
            S_ALUWB:    begin o.reg_write = 1'b1; end
            S_BEQ:      begin o.alu_src_a = 2'b10; o.alu_op = 2'b01; o.beq_gate = 1'b1; end
            S_JAL:      begin o.alu_src_a = 2'b01; o.alu_src_b = 2'b10; o.pc_write = 1'b1; end
            S_LUI:      begin o.alu_src_a = 2'b11; o.alu_src_b = 2'b01; end
            S_FAULT:    begin o.err = 1'b1; end
            default:    begin o.err = 1'b1; end
        endcase
        return o;
    endfunction

    // Next-state logic.
    always_comb begin
        state_d = state_q;
        case (state_q)
            S_FETCH: begin
                if (mem_ready)      state_d = S_DECODE;
                else if (timeout_s) state_d = S_FAULT;
                else                state_d = S_FETCH;
            end
            S_DECODE: begin
                case (op)
                    OP_LOAD, OP_STORE: state_d = S_MEMADR;
                    OP_R:              state_d = S_EXECR;
                    OP_I:              state_d = S_EXECI;
                    OP_BRANCH:         state_d = S_BEQ;
                    OP_JAL:            state_d = S_JAL;
                    OP_LUI:            state_d = S_LUI;
                    default:           state_d = S_FAULT;
                endcase
            end
            S_MEMADR: begin
                if (op == OP_STORE) state_d = S_MEMWRITE;
                else                state_d = S_MEMREAD;
            end
            S_MEMREAD: begin
                if (mem_ready)      state_d = S_MEMWB;
                else if (timeout_s) state_d = S_FAULT;
                else                state_d = S_MEMREAD;
            end
            S_MEMWRITE: begin
                if (mem_ready)      state_d = S_FETCH;
                else if (timeout_s) state_d = S_FAULT;
                else                state_d = S_MEMWRITE;
            end
            S_MEMWB, S_ALUWB, S_BEQ:        state_d = S_FETCH;
            S_EXECR, S_EXECI, S_JAL, S_LUI: state_d = S_ALUWB;
            S_FAULT:                        state_d = S_FAULT;
            default:                        state_d = S_FAULT;
        endcase
    end

    // State and registered Moore outputs, both derived from the next state.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state_q <= S_FETCH;
            outs_q  <= decode_outs(S_FETCH);
        end else begin
            state_q <= state_d;
            outs_q  <= decode_outs(state_d);
        end
    end

`ifdef CTRL_MEM_TIMEOUT_EN
    localparam logic [7:0] LAST_WAIT = 8'(MEM_TIMEOUT - 1);

    logic [7:0] wait_q, wait_d;
    logic       waiting_s;

    assign waiting_s = (state_q == S_FETCH) || (state_q == S_MEMREAD) || (state_q == S_MEMWRITE);
    // mem_ready on the final permitted cycle still completes the access.
    assign timeout_s = waiting_s && !mem_ready && (wait_q == LAST_WAIT);

    // Count stalled cycles; any state change clears the count.
    always_comb begin
        if (waiting_s && !mem_ready && (state_d == state_q)) begin
            wait_d = wait_q + 8'd1;
        end else begin
            wait_d = 8'd0;
        end
    end

    // Wait counter register.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            wait_q <= 8'd0;
        end else begin
            wait_q <= wait_d;
        end
    end
`else
    assign timeout_s = 1'b0;
`endif

    // Immediate format follows the opcode in every state.
    always_comb begin
        case (op)
            OP_LOAD, OP_I: imm_src = 3'b000;
            OP_STORE:      imm_src = 3'b001;
            OP_BRANCH:     imm_src = 3'b010;
            OP_JAL:        imm_src = 3'b011;
            OP_LUI:        imm_src = 3'b100;
            default:       imm_src = 3'b111;
        endcase
    end

    assign mem_req    = outs_q.mem_req;
    assign mem_write  = outs_q.mem_write;
    assign reg_write  = outs_q.reg_write;
    assign adr_src    = outs_q.adr_src;
    assign err        = outs_q.err;
    assign alu_src_a  = outs_q.alu_src_a;
    assign alu_src_b  = outs_q.alu_src_b;
    assign alu_op     = outs_q.alu_op;
    assign result_src = outs_q.result_src;
    assign ir_write   = outs_q.fetch_gate & mem_ready & ~reset;
    assign pc_write   = outs_q.pc_write | (outs_q.fetch_gate & mem_ready & ~reset) | (outs_q.beq_gate & zero);

endmodule

// File: tb/tb_multicycle_controller.sv
// Directed self-checking bench for multicycle_controller (MEM_TIMEOUT=4).
module tb_multicycle_controller;

    logic       clk = 1'b0;
    logic       reset;
    logic [6:0] op;
    logic       zero;
    logic       mem_ready;
    logic       mem_req, mem_write, pc_write, ir_write, reg_write, adr_src, err;
    logic [1:0] alu_src_a, alu_src_b, alu_op, result_src;
    logic [2:0] imm_src;

    int n_checks = 0;
    int n_pass   = 0;

    // {mem_req,mem_write,pc_write,ir_write,reg_write,adr_src,err, a,b,alu_op,result_src}
    localparam logic [14:0] SIG_FETCH_WAIT = 15'b1000000_00100010;
    localparam logic [14:0] SIG_FETCH_GO   = 15'b1011000_00100010;
    localparam logic [14:0] SIG_DECODE     = 15'b0000000_01010000;
    localparam logic [14:0] SIG_MEMADR     = 15'b0000000_10010000;
    localparam logic [14:0] SIG_MEMREAD    = 15'b1000010_00000000;
    localparam logic [14:0] SIG_MEMWB      = 15'b0000100_00000001;
    localparam logic [14:0] SIG_MEMWRITE   = 15'b1100010_00000000;
    localparam logic [14:0] SIG_EXECR      = 15'b0000000_10001000;
    localparam logic [14:0] SIG_EXECI      = 15'b0000000_10011000;
    localparam logic [14:0] SIG_ALUWB      = 15'b0000100_00000000;
    localparam logic [14:0] SIG_BEQ_TAKEN  = 15'b0010000_10000100;
    localparam logic [14:0] SIG_BEQ_NOT    = 15'b0000000_10000100;
    localparam logic [14:0] SIG_JAL        = 15'b0010000_01100000;
    localparam logic [14:0] SIG_LUI        = 15'b0000000_11010000;
    localparam logic [14:0] SIG_FAULT      = 15'b0000001_00000000;

    multicycle_controller #(.MEM_TIMEOUT(4)) dut (
        .clk        (clk),
        .reset      (reset),
        .op         (op),
        .zero       (zero),
        .mem_ready  (mem_ready),
        .mem_req    (mem_req),
        .mem_write  (mem_write),
        .pc_write   (pc_write),
        .ir_write   (ir_write),
        .reg_write  (reg_write),
        .adr_src    (adr_src),
        .alu_src_a  (alu_src_a),
        .alu_src_b  (alu_src_b),
        .alu_op     (alu_op),
        .result_src (result_src),
        .imm_src    (imm_src),
        .err        (err)
    );

    always #5 clk = ~clk;

    task automatic check_sig(input string tag, input logic [14:0] exp);
        logic [14:0] obs;
        obs = {mem_req, mem_write, pc_write, ir_write, reg_write, adr_src, err,
               alu_src_a, alu_src_b, alu_op, result_src};
        n_checks++;
        assert (obs === exp) n_pass++;
        else $error("FAIL %s: observed %b expected %b", tag, obs, exp);
    endtask

    task automatic check_imm(input string tag, input logic [2:0] exp);
        n_checks++;
        assert (imm_src === exp) n_pass++;
        else $error("FAIL %s: imm_src observed %b expected %b", tag, imm_src, exp);
    endtask

    // One clock cycle: drive inputs just after the edge, check, advance.
    task automatic cyc(input logic rdy, input logic z, input string tag, input logic [14:0] exp);
        mem_ready = rdy;
        zero      = z;
        #1;
        check_sig(tag, exp);
        @(posedge clk);
        #1;
    endtask

    initial begin
        reset = 1'b1; op = 7'b0000011; zero = 1'b0; mem_ready = 1'b1;
        repeat (2) @(posedge clk);
        #1;
        check_sig("reset_state", SIG_FETCH_WAIT);
        reset = 1'b0;

        // lw, memory always ready
        op = 7'b0000011;
        cyc(1'b1, 1'b0, "lw_fetch",   SIG_FETCH_GO);
        check_imm("lw_imm", 3'b000);
        cyc(1'b1, 1'b0, "lw_decode",  SIG_DECODE);
        cyc(1'b1, 1'b0, "lw_memadr",  SIG_MEMADR);
        cyc(1'b1, 1'b0, "lw_memread", SIG_MEMREAD);
        cyc(1'b1, 1'b0, "lw_memwb",   SIG_MEMWB);

        // sw, three stalled cycles in MEMWRITE
        op = 7'b0100011;
        cyc(1'b1, 1'b0, "sw_fetch",  SIG_FETCH_GO);
        check_imm("sw_imm", 3'b001);
        cyc(1'b1, 1'b0, "sw_decode", SIG_DECODE);
        cyc(1'b1, 1'b0, "sw_memadr", SIG_MEMADR);
        for (int i = 0; i < 3; i++) cyc(1'b0, 1'b0, "sw_memwrite_wait", SIG_MEMWRITE);
        cyc(1'b1, 1'b0, "sw_memwrite_done", SIG_MEMWRITE);
        cyc(1'b0, 1'b0, "sw_back_to_fetch", SIG_FETCH_WAIT);

        // beq taken then not taken
        op = 7'b1100011;
        cyc(1'b1, 1'b1, "beq1_fetch",  SIG_FETCH_GO);
        check_imm("beq_imm", 3'b010);
        cyc(1'b1, 1'b1, "beq1_decode", SIG_DECODE);
        cyc(1'b1, 1'b1, "beq1_taken",  SIG_BEQ_TAKEN);
        cyc(1'b1, 1'b0, "beq2_fetch",  SIG_FETCH_GO);
        cyc(1'b1, 1'b0, "beq2_decode", SIG_DECODE);
        cyc(1'b1, 1'b0, "beq2_not",    SIG_BEQ_NOT);

        // R-type, I-type, jal, lui
        op = 7'b0110011;
        cyc(1'b1, 1'b0, "r_fetch",  SIG_FETCH_GO);
        check_imm("r_imm", 3'b111);
        cyc(1'b1, 1'b0, "r_decode", SIG_DECODE);
        cyc(1'b1, 1'b0, "r_exec",   SIG_EXECR);
        cyc(1'b1, 1'b0, "r_aluwb",  SIG_ALUWB);
        op = 7'b0010011;
        cyc(1'b1, 1'b0, "i_fetch",  SIG_FETCH_GO);
        check_imm("i_imm", 3'b000);
        cyc(1'b1, 1'b0, "i_decode", SIG_DECODE);
        cyc(1'b1, 1'b0, "i_exec",   SIG_EXECI);
        cyc(1'b1, 1'b0, "i_aluwb",  SIG_ALUWB);
        op = 7'b1101111;
        cyc(1'b1, 1'b0, "jal_fetch",  SIG_FETCH_GO);
        check_imm("jal_imm", 3'b011);
        cyc(1'b1, 1'b0, "jal_decode", SIG_DECODE);
        cyc(1'b1, 1'b0, "jal_exec",   SIG_JAL);
        cyc(1'b1, 1'b0, "jal_aluwb",  SIG_ALUWB);
        op = 7'b0110111;
        cyc(1'b1, 1'b0, "lui_fetch",  SIG_FETCH_GO);
        check_imm("lui_imm", 3'b100);
        cyc(1'b1, 1'b0, "lui_decode", SIG_DECODE);
        cyc(1'b1, 1'b0, "lui_exec",   SIG_LUI);
        cyc(1'b1, 1'b0, "lui_aluwb",  SIG_ALUWB);

        // Reset mid-MEMREAD takes effect without a clock edge
        op = 7'b0000011;
        cyc(1'b1, 1'b0, "rst_lw_fetch",  SIG_FETCH_GO);
        cyc(1'b1, 1'b0, "rst_lw_decode", SIG_DECODE);
        cyc(1'b1, 1'b0, "rst_lw_memadr", SIG_MEMADR);
        mem_ready = 1'b0;
        #1;
        check_sig("rst_lw_memread", SIG_MEMREAD);
        #2;
        reset = 1'b1;
        mem_ready = 1'b1;
        #1;
        check_sig("rst_async_fetch", SIG_FETCH_WAIT);
        @(posedge clk);
        #1;
        check_sig("rst_held", SIG_FETCH_WAIT);
        reset = 1'b0;
        cyc(1'b1, 1'b0, "rst_first_fetch", SIG_FETCH_GO);
        cyc(1'b1, 1'b0, "rst_first_decode", SIG_DECODE);
        cyc(1'b1, 1'b0, "rst_memadr2", SIG_MEMADR);
        cyc(1'b1, 1'b0, "rst_memread2", SIG_MEMREAD);
        cyc(1'b1, 1'b0, "rst_memwb2", SIG_MEMWB);

        op = 7'b0110011;
`ifdef CTRL_MEM_TIMEOUT_EN
        // Ready on the 4th stalled cycle still completes the fetch
        for (int i = 0; i < 3; i++) cyc(1'b0, 1'b0, "to_wait", SIG_FETCH_WAIT);
        cyc(1'b1, 1'b0, "to_last_ready", SIG_FETCH_GO);
        cyc(1'b1, 1'b0, "to_decode", SIG_DECODE);
        cyc(1'b1, 1'b0, "to_exec",   SIG_EXECR);
        cyc(1'b1, 1'b0, "to_aluwb",  SIG_ALUWB);
        for (int i = 0; i < 4; i++) cyc(1'b0, 1'b0, "to_stall", SIG_FETCH_WAIT);
        cyc(1'b1, 1'b0, "to_fault", SIG_FAULT);
`else
        // Without the timeout, a long stall never faults
        for (int i = 0; i < 20; i++) cyc(1'b0, 1'b0, "nto_wait", SIG_FETCH_WAIT);
        cyc(1'b1, 1'b0, "nto_fetch", SIG_FETCH_GO);
        cyc(1'b1, 1'b0, "nto_decode", SIG_DECODE);
        cyc(1'b1, 1'b0, "nto_exec",   SIG_EXECR);
        cyc(1'b1, 1'b0, "nto_aluwb",  SIG_ALUWB);
`endif
        reset = 1'b1;
        #1;
        check_sig("reset_again", SIG_FETCH_WAIT);
        @(posedge clk);
        #1;
        reset = 1'b0;

        // Illegal opcode faults after DECODE and stays until reset
        op = 7'b1111111;
        cyc(1'b1, 1'b0, "ill_fetch",  SIG_FETCH_GO);
        check_imm("ill_imm", 3'b111);
        cyc(1'b1, 1'b0, "ill_decode", SIG_DECODE);
        for (int i = 0; i < 3; i++) cyc(1'b1, 1'b1, "ill_fault", SIG_FAULT);
        reset = 1'b1;
        #1;
        check_sig("ill_reset", SIG_FETCH_WAIT);
        @(posedge clk);
        #1;
        reset = 1'b0;
        op = 7'b0000011;
        cyc(1'b1, 1'b0, "post_fetch", SIG_FETCH_GO);
        cyc(1'b1, 1'b0, "post_decode", SIG_DECODE);

        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

endmodule
